// File: rtl/piso_pkg.sv
// Shared definitions for the serializer family: FSM state encoding and bit-order codes.
// No logic; imported by piso_serializer and the sipo side of the family.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer; first bit presented the cycle after acceptance, DATA_W cycles per word at full rate.
// Backpressure: out_en stalls the presented bit indefinitely; in_ready only in IDLE or on the consumed last bit (gapless reload).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_msb_first,
    input  logic              out_en,
    input  logic              abort,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              serial_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    if (DATA_W < 2) begin : g_bad_width
        $error("piso_serializer: DATA_W must be >= 2");
    end

    piso_state_t       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              order_q, order_d;

    logic in_shift;
    logic word_done;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        order_d  = order_q;

        in_shift     = (state_q == SHIFT);
        serial_valid = in_shift;
        busy         = in_shift;
        serial_last  = in_shift && (cnt_q == LAST_CNT);
        serial_out   = in_shift && ((order_q == ORDER_MSB) ? shreg_q[DATA_W-1] : shreg_q[0]);
        word_done    = serial_last && out_en;
        in_ready     = !abort && (!in_shift || word_done);

        // Abort outranks everything, including a word offered in the same cycle.
        if (abort) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            order_d = ORDER_LSB;
        end else if (in_valid && in_ready) begin
            state_d = SHIFT;
            shreg_d = in_data;
            cnt_d   = '0;
            order_d = in_msb_first;
        end else if (word_done) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            order_d = ORDER_LSB;
        end else if (in_shift && out_en) begin
            shreg_d = (order_q == ORDER_MSB) ? {shreg_q[DATA_W-2:0], 1'b0}
                                             : {1'b0, shreg_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_LSB;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed word tables and corner sequences, then random traffic against a bit-queue model.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [11:0] in_data12 = '0;
    logic        in_msb_first = 1'b0;
    logic        out_en = 1'b0;
    logic        abort = 1'b0;

    logic in_ready, serial_out, serial_valid, serial_last, busy;
    logic in_ready12, serial_out12, serial_valid12, serial_last12, busy12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_msb_first(in_msb_first), .out_en(out_en), .abort(abort),
        .serial_out(serial_out), .serial_valid(serial_valid), .serial_last(serial_last), .busy(busy)
    );

    piso_serializer #(.DATA_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
        .in_data(in_data12), .in_msb_first(in_msb_first), .out_en(out_en), .abort(abort),
        .serial_out(serial_out12), .serial_valid(serial_valid12), .serial_last(serial_last12), .busy(busy12)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic set_in(input logic v, input logic [7:0] d, input logic m,
                          input logic oe, input logic ab);
        @(negedge clk);
        in_valid     = v;
        in_data      = d;
        in_msb_first = m;
        out_en       = oe;
        abort        = ab;
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_valid"}, serial_valid, 1'b0);
        chk({nm, "_busy"},  busy,         1'b0);
        chk({nm, "_out"},   serial_out,   1'b0);
        chk({nm, "_last"},  serial_last,  1'b0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] seq;   // seq[i] = i-th bit put on the wire
    } vec_t;

    vec_t vecs[7];

    // Reference model: the bits still owed for the current word, front = presented bit.
    bit   mq[$];
    logic [11:0] w12;

    task automatic model_load(input logic [7:0] d, input logic m);
        mq.delete();
        for (int i = 0; i < 8; i++) mq.push_back(m ? d[7-i] : d[i]);
    endtask

    initial begin
        vecs[0] = '{8'hC1, 1'b0, 8'hC1};
        vecs[1] = '{8'hC1, 1'b1, 8'h83};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C};
        vecs[3] = '{8'hA5, 1'b0, 8'hA5};
        vecs[4] = '{8'hA5, 1'b1, 8'hA5};
        vecs[5] = '{8'h01, 1'b1, 8'h80};
        vecs[6] = '{8'h80, 1'b1, 8'h01};

        // Reset
        #12;
        chk_idle("rst_hold");
        set_in(0, 8'h00, 0, 1, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk_idle("rst_rel");

        // Table of single words at full rate
        foreach (vecs[k]) begin
            set_in(1, vecs[k].data, vecs[k].msb, 1, 0);
            chk($sformatf("tbl%0d_accept_rdy", k), in_ready, 1'b1);
            chk($sformatf("tbl%0d_accept_vld", k), serial_valid, 1'b0);
            for (int i = 0; i < 8; i++) begin
                set_in(0, 8'h00, 0, 1, 0);
                chk($sformatf("tbl%0d_b%0d_vld", k, i), serial_valid, 1'b1);
                chk($sformatf("tbl%0d_b%0d_bit", k, i), serial_out, vecs[k].seq[i]);
                chk($sformatf("tbl%0d_b%0d_last", k, i), serial_last, (i == 7));
                chk($sformatf("tbl%0d_b%0d_rdy", k, i), in_ready, (i == 7));
            end
            set_in(0, 8'h00, 0, 1, 0);
            chk_idle($sformatf("tbl%0d_end", k));
            chk($sformatf("tbl%0d_end_rdy", k), in_ready, 1'b1);
        end

        // Back-to-back: C1 LSB then 3C MSB, in_valid held
        begin
            logic [15:0] seq;
            seq = {8'h3C, 8'hC1};
            set_in(1, 8'hC1, 0, 1, 0);
            for (int i = 0; i < 16; i++) begin
                if (i < 8) set_in(1, 8'h3C, 1, 1, 0);
                else       set_in(0, 8'h00, 0, 1, 0);
                chk($sformatf("b2b_b%0d_vld", i), serial_valid, 1'b1);
                chk($sformatf("b2b_b%0d_bit", i), serial_out, seq[i]);
                chk($sformatf("b2b_b%0d_rdy", i), in_ready, (i == 7 || i == 15));
                chk($sformatf("b2b_b%0d_last", i), serial_last, (i == 7 || i == 15));
            end
            set_in(0, 8'h00, 0, 1, 0);
            chk_idle("b2b_end");
        end

        // Stall: C1 MSB = 1,1,0,0,0,0,0,1 ; hold 4th bit for 4 cycles
        begin
            logic [7:0] seq;
            seq = 8'h83;
            set_in(1, 8'hC1, 1, 1, 0);
            for (int i = 0; i < 3; i++) begin
                set_in(0, 8'h00, 0, 1, 0);
                chk($sformatf("stall_pre%0d", i), serial_out, seq[i]);
            end
            for (int s = 0; s < 4; s++) begin
                set_in(1, 8'hFF, 1, 0, 0);
                chk($sformatf("stall_s%0d_bit", s), serial_out, 1'b0);
                chk($sformatf("stall_s%0d_vld", s), serial_valid, 1'b1);
                chk($sformatf("stall_s%0d_last", s), serial_last, 1'b0);
                chk($sformatf("stall_s%0d_rdy", s), in_ready, 1'b0);
            end
            for (int i = 3; i < 8; i++) begin
                set_in(0, 8'h00, 0, 1, 0);
                chk($sformatf("stall_post%0d_bit", i), serial_out, seq[i]);
                chk($sformatf("stall_post%0d_last", i), serial_last, (i == 7));
            end
            set_in(0, 8'h00, 0, 1, 0);
            chk_idle("stall_end");
        end

        // Abort on the 4th bit with a word offered
        set_in(1, 8'hC1, 0, 1, 0);
        for (int i = 0; i < 3; i++) set_in(0, 8'h00, 0, 1, 0);
        set_in(1, 8'hFF, 1, 1, 1);
        chk("abort_rdy", in_ready, 1'b0);
        chk("abort_vld", serial_valid, 1'b1);
        set_in(0, 8'h00, 0, 1, 0);
        chk_idle("abort_next");
        chk("abort_next_rdy", in_ready, 1'b1);
        set_in(0, 8'h00, 0, 1, 0);
        chk_idle("abort_next2");

        // Abort in IDLE: only in_ready drops, nothing is loaded
        set_in(1, 8'hAA, 0, 1, 1);
        chk("abort_idle_rdy", in_ready, 1'b0);
        set_in(0, 8'h00, 0, 1, 0);
        chk_idle("abort_idle_next");

        // Reset pulse mid-word, asserted mid-clock
        set_in(1, 8'hC1, 0, 1, 0);
        for (int i = 0; i < 3; i++) set_in(0, 8'h00, 0, 1, 0);
        chk("rstmid_pre_vld", serial_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("rstmid_now");
        set_in(0, 8'h00, 0, 1, 0);
        rst_n = 1'b1;
        set_in(0, 8'h00, 0, 1, 0);
        chk_idle("rstmid_after");
        chk("rstmid_rdy", in_ready, 1'b1);

        // DATA_W=12, 12'hA5C, LSB then MSB first
        for (int m = 0; m < 2; m++) begin
            w12 = 12'hA5C;
            @(negedge clk);
            in_data12 = w12;
            set_in(1, 8'h00, m[0], 1, 0);
            chk($sformatf("w12_m%0d_rdy", m), in_ready12, 1'b1);
            for (int i = 0; i < 12; i++) begin
                set_in(0, 8'h00, 0, 1, 0);
                chk($sformatf("w12_m%0d_b%0d_bit", m, i), serial_out12, (m == 1) ? w12[11-i] : w12[i]);
                chk($sformatf("w12_m%0d_b%0d_last", m, i), serial_last12, (i == 11));
            end
            set_in(0, 8'h00, 0, 1, 0);
            chk($sformatf("w12_m%0d_end_vld", m), serial_valid12, 1'b0);
        end

        // Random traffic against the queue model (dut8 idle here)
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic v, m, oe, ab, exp_rdy, exp_vld;
            logic [7:0] d;
            v  = ($urandom_range(0, 2) != 0);
            d  = 8'($urandom);
            m  = 1'($urandom);
            oe = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 39) == 0);
            set_in(v, d, m, oe, ab);
            exp_vld = (mq.size() > 0);
            exp_rdy = !ab && (mq.size() == 0 || (oe && mq.size() == 1));
            chk("rnd_vld",  serial_valid, exp_vld);
            chk("rnd_busy", busy,         exp_vld);
            chk("rnd_bit",  serial_out,   exp_vld ? mq[0] : 1'b0);
            chk("rnd_last", serial_last,  (mq.size() == 1));
            chk("rnd_rdy",  in_ready,     exp_rdy);
            if (ab)                     mq.delete();
            else if (v && exp_rdy)      model_load(d, m);
            else if (exp_vld && oe)     void'(mq.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
